// File: rtl/ste_bus_pkg.sv
// Shared types and helpers for the ST bus-mastership arbiter and its
// priority selector.
package ste_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_AS,
    GRANT,
    OWNED,
    RELEASE
  } arb_state_t;

  localparam int unsigned REQ_DMA   = 0;
  localparam int unsigned REQ_BLIT  = 1;
  localparam int unsigned MAX_NREQ  = 16;

  // Callers truncate the result to their own request width.
  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/ste_bus_arbiter_if.sv
// Bus-mastership handshake between the alternate masters and the arbiter.
// master = requesting side, slave = arbiter side.
interface ste_bus_arbiter_if #(
  parameter int NREQ = 2
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            as_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] grant;
  logic [OW-1:0]   owner;
  logic            bgack_n;
  logic            bus_free;
  logic [NREQ-1:0] yield;
  logic            timeout;
  logic            err_busy;

  modport master (
    output as_n, req, busy,
    input  grant, owner, bgack_n, bus_free, yield, timeout, err_busy
  );

  modport slave (
    input  as_n, req, busy,
    output grant, owner, bgack_n, bus_free, yield, timeout, err_busy
  );

endinterface

// File: rtl/ste_bus_arbiter_prio_sel.sv
// Combinational rotating priority encoder: first set request at or after
// the start pointer (pointer forced to 0 when rotation is disabled).
module bus_prio_sel #(
  parameter int NREQ = 2,
  parameter int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_rr_ptr,
  input  logic            i_rr_en,
  output logic [OW-1:0]   o_winner,
  output logic            o_valid
);

  always_comb begin
    int unsigned start;
    int unsigned idx;
    o_winner = '0;
    o_valid  = 1'b0;
    start    = i_rr_en ? 32'(i_rr_ptr) : 0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (!o_valid && i_req[OW'(idx)]) begin
        o_valid  = 1'b1;
        o_winner = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/ste_bus_arbiter.sv
// 68000-style BR/BG/BGACK sequencer between the CPU and NREQ alternate
// masters; decisions are taken only on 8 MHz bus-phase ticks.
module ste_bus_arbiter
  import ste_bus_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int ROUND_ROBIN   = 0,
  parameter int GRANT_TIMEOUT = 8,
  parameter int MAX_HOLD      = 64
) (
  input  logic               clk32,
  input  logic               reset,
  input  logic               clk_en,
  ste_bus_arbiter_if.slave   bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t      r_state,    w_state_n;
  logic [NREQ-1:0] r_grant,    w_grant_n;
  logic [OW-1:0]   r_owner,    w_owner_n;
  logic            r_bgack_n,  w_bgack_n_n;
  logic            r_bus_free, w_bus_free_n;
  logic [NREQ-1:0] r_yield,    w_yield_n;
  logic            r_timeout,  w_timeout_n;
  logic            r_err_busy, w_err_busy_n;
  logic [OW-1:0]   r_rr_ptr,   w_rr_ptr_n;
  logic [TW-1:0]   r_tcnt,     w_tcnt_n;
  logic [HW-1:0]   r_hcnt,     w_hcnt_n;

  logic [OW-1:0]   w_winner;
  logic            w_valid;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_own_oh;
  logic [NREQ-1:0] w_allowed;
  logic            w_own_req;
  logic            w_own_busy;
  logic            w_others_req;
  logic [HW-1:0]   w_hcnt_inc;

  bus_prio_sel #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_prio_sel (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .i_rr_en  (ROUND_ROBIN != 0),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_comb begin
    w_win_oh     = NREQ'(onehot(32'(w_winner)));
    w_own_oh     = NREQ'(onehot(32'(r_owner)));
    w_own_req    = |(bus.req & w_own_oh);
    w_own_busy   = |(bus.busy & w_own_oh);
    w_others_req = |(bus.req & ~w_own_oh);
    w_hcnt_inc   = (r_hcnt == HW'(MAX_HOLD)) ? r_hcnt : r_hcnt + 1'b1;
    // Only the granted or owning master may legitimately drive busy.
    w_allowed    = (r_state == GRANT || r_state == OWNED) ? w_own_oh : '0;
  end

  always_comb begin
    w_state_n    = r_state;
    w_grant_n    = r_grant;
    w_owner_n    = r_owner;
    w_bgack_n_n  = r_bgack_n;
    w_bus_free_n = r_bus_free;
    w_yield_n    = r_yield;
    w_timeout_n  = 1'b0;
    w_err_busy_n = r_err_busy;
    w_rr_ptr_n   = r_rr_ptr;
    w_tcnt_n     = r_tcnt;
    w_hcnt_n     = r_hcnt;

    if (clk_en) begin
      if (|(bus.busy & ~w_allowed)) begin
        w_err_busy_n = 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            w_owner_n = w_winner;
            if (bus.as_n) begin
              w_state_n    = GRANT;
              w_grant_n    = w_win_oh;
              w_bus_free_n = 1'b0;
            end else begin
              w_state_n = WAIT_AS;
            end
          end
        end

        WAIT_AS: begin
          if (!w_own_req) begin
            w_state_n = IDLE;
            w_owner_n = '0;
          end else if (bus.as_n) begin
            w_state_n    = GRANT;
            w_grant_n    = w_own_oh;
            w_bus_free_n = 1'b0;
          end
        end

        GRANT: begin
          if (w_own_busy) begin
            w_state_n   = OWNED;
            w_grant_n   = '0;
            w_bgack_n_n = 1'b0;
            w_tcnt_n    = '0;
            w_hcnt_n    = '0;
          end else if (!w_own_req || r_tcnt == TW'(GRANT_TIMEOUT - 1)) begin
            w_state_n    = IDLE;
            w_grant_n    = '0;
            w_bus_free_n = 1'b1;
            w_owner_n    = '0;
            w_tcnt_n     = '0;
            w_timeout_n  = w_own_req;
          end else begin
            w_tcnt_n = r_tcnt + 1'b1;
          end
        end

        OWNED: begin
          if (!w_own_busy) begin
            w_state_n   = RELEASE;
            w_bgack_n_n = 1'b1;
            w_yield_n   = '0;
          end else begin
            w_hcnt_n  = w_hcnt_inc;
            w_yield_n = (w_hcnt_inc >= HW'(MAX_HOLD) && w_others_req) ? w_own_oh : '0;
          end
        end

        RELEASE: begin
          w_state_n    = IDLE;
          w_bus_free_n = 1'b1;
          w_yield_n    = '0;
          w_owner_n    = '0;
          w_hcnt_n     = '0;
          if (ROUND_ROBIN != 0) begin
            w_rr_ptr_n = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end

        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_bgack_n  <= 1'b1;
      r_bus_free <= 1'b1;
      r_yield    <= '0;
      r_timeout  <= 1'b0;
      r_err_busy <= 1'b0;
      r_rr_ptr   <= '0;
      r_tcnt     <= '0;
      r_hcnt     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_grant    <= w_grant_n;
      r_owner    <= w_owner_n;
      r_bgack_n  <= w_bgack_n_n;
      r_bus_free <= w_bus_free_n;
      r_yield    <= w_yield_n;
      r_timeout  <= w_timeout_n;
      r_err_busy <= w_err_busy_n;
      r_rr_ptr   <= w_rr_ptr_n;
      r_tcnt     <= w_tcnt_n;
      r_hcnt     <= w_hcnt_n;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.owner    = r_owner;
  assign bus.bgack_n  = r_bgack_n;
  assign bus.bus_free = r_bus_free;
  assign bus.yield    = r_yield;
  assign bus.timeout  = r_timeout;
  assign bus.err_busy = r_err_busy;

endmodule

// File: tb/tb_ste_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected output snapshots tagged with
// the clk32 cycle they apply to; a negedge monitor pops and compares them.
module tb_ste_bus_arbiter;

  logic       clk32;
  logic       reset;
  logic       clk_en;
  logic [1:0] div;
  int unsigned cyc;

  int n_checks;
  int n_pass;

  typedef struct {
    int unsigned cyc;
    int          d;
    string       name;
    logic [8:0]  val;
  } exp_t;

  exp_t q[$];

  ste_bus_arbiter_if #(.NREQ(2)) ia ();
  ste_bus_arbiter_if #(.NREQ(2)) ib ();

  ste_bus_arbiter #(
    .NREQ          (2),
    .ROUND_ROBIN   (0),
    .GRANT_TIMEOUT (8),
    .MAX_HOLD      (64)
  ) u_fixed (
    .clk32  (clk32),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (ia)
  );

  ste_bus_arbiter #(
    .NREQ          (2),
    .ROUND_ROBIN   (1),
    .GRANT_TIMEOUT (8),
    .MAX_HOLD      (64)
  ) u_rr (
    .clk32  (clk32),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (ib)
  );

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  // Bus-phase enable: one clk32 in four, changing on the falling edge.
  initial div = 2'd0;
  always @(negedge clk32) div <= div + 2'd1;
  assign clk_en = (div == 2'd3);

  initial cyc = 0;
  always @(posedge clk32) cyc <= cyc + 1;

  function automatic logic [8:0] snap(input int d);
    if (d == 0)
      return {ia.grant, ia.owner, ia.bgack_n, ia.bus_free, ia.yield, ia.timeout, ia.err_busy};
    return {ib.grant, ib.owner, ib.bgack_n, ib.bus_free, ib.yield, ib.timeout, ib.err_busy};
  endfunction

  always @(negedge clk32) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [8:0] act;
      e   = q.pop_front();
      act = snap(e.d);
      n_checks++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s: got %b want %b (grant,owner,bgack_n,bus_free,yield,timeout,err)",
                    e.name, act, e.val);
    end
  end

  task automatic expect_out(input string name, input int d, input logic [1:0] g,
                            input logic o, input logic bg, input logic bf,
                            input logic [1:0] y, input logic to, input logic eb,
                            input int unsigned dly = 0);
    exp_t e;
    e.cyc  = cyc + dly;
    e.d    = d;
    e.name = name;
    e.val  = {g, o, bg, bf, y, to, eb};
    q.push_back(e);
  endtask

  task automatic step();
    do @(posedge clk32); while (!clk_en);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    ia.req = 2'b11; ia.as_n = 1'b0; ia.busy = 2'b00;
    ib.req = 2'b00; ib.as_n = 1'b1; ib.busy = 2'b00;
    repeat (6) @(posedge clk32);
    #1;
    expect_out("reset_state", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    expect_out("reset_state_rr", 1, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    step();
    reset = 1'b0;

    // Basic grant / own / release with latencies.
    ia.req = 2'b01; ia.as_n = 1'b1;
    step(); expect_out("grant_dma", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    step(); expect_out("grant_hold", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    ia.busy = 2'b01;
    step(); expect_out("owned_dma", 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    repeat (7) step();
    expect_out("owned_dma_t9", 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    ia.busy = 2'b00; ia.req = 2'b00;
    step(); expect_out("release", 0, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    step(); expect_out("bus_free_after_release", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);

    // Address strobe active: wait, then grant the latched owner.
    ia.req = 2'b10; ia.as_n = 1'b0;
    step(); expect_out("wait_as_1", 0, 2'b00, 1, 1, 1, 2'b00, 0, 0);
    step(); step(); expect_out("wait_as_3", 0, 2'b00, 1, 1, 1, 2'b00, 0, 0);
    ia.as_n = 1'b1;
    step(); expect_out("grant_after_as", 0, 2'b10, 1, 1, 0, 2'b00, 0, 0);
    ia.req = 2'b00;
    step(); expect_out("withdraw_in_grant", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);

    // Fixed priority: DMA twice in a row.
    ia.req = 2'b11;
    step(); expect_out("fixed_first", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    ia.busy = 2'b01; step();
    ia.busy = 2'b00; step();
    step(); expect_out("fixed_idle", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    step(); expect_out("fixed_second", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    ia.busy = 2'b01; step();
    ia.busy = 2'b00; step();
    ia.req = 2'b00; step();

    // Grant timeout and re-grant.
    ia.req = 2'b01;
    step(); expect_out("to_grant", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    repeat (7) step();
    expect_out("to_tick7", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    step();
    expect_out("to_pulse", 0, 2'b00, 0, 1, 1, 2'b00, 1, 0);
    expect_out("to_pulse_clear", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0, 1);
    step(); expect_out("to_regrant", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    ia.req = 2'b00;
    step(); expect_out("to_drop", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);

    // Yield after MAX_HOLD ticks of blitter ownership.
    ia.req = 2'b10;
    step(); expect_out("blit_grant", 0, 2'b10, 1, 1, 0, 2'b00, 0, 0);
    ia.busy = 2'b10; ia.req = 2'b11;
    step(); expect_out("blit_owned", 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    repeat (63) step();
    expect_out("yield_not_yet", 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    step(); expect_out("yield_on", 0, 2'b00, 1, 0, 0, 2'b10, 0, 0);
    step(); expect_out("yield_held", 0, 2'b00, 1, 0, 0, 2'b10, 0, 0);
    ia.busy = 2'b00; ia.req = 2'b01;
    step(); expect_out("yield_release", 0, 2'b00, 1, 1, 0, 2'b00, 0, 0);
    step(); expect_out("yield_idle", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    step(); expect_out("dma_after_yield", 0, 2'b01, 0, 1, 0, 2'b00, 0, 0);

    // Non-owner busy: sticky error, ownership unaffected.
    ia.busy = 2'b01;
    step(); expect_out("dma_owned", 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    ia.busy = 2'b11;
    step(); expect_out("err_busy_set", 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
    ia.busy = 2'b01;
    step(); expect_out("err_busy_sticky", 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);

    // Round robin: 01, 10, 01 across three ownerships.
    ib.req = 2'b11;
    step(); expect_out("rr_first", 1, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    ib.busy = 2'b01; step();
    ib.busy = 2'b00; step();
    step();
    step(); expect_out("rr_second", 1, 2'b10, 1, 1, 0, 2'b00, 0, 0);
    ib.busy = 2'b10; step();
    ib.busy = 2'b00; step();
    step();
    step(); expect_out("rr_third", 1, 2'b01, 0, 1, 0, 2'b00, 0, 0);
    ib.req = 2'b00;

    // Reset mid-OWNED on a clk32 edge where clk_en is low.
    reset = 1'b1;
    @(posedge clk32); #1;
    expect_out("reset_mid_owned", 0, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    expect_out("reset_rr", 1, 2'b00, 0, 1, 1, 2'b00, 0, 0);
    repeat (4) @(posedge clk32);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ste_bus_arbiter.md
Name: ste_bus_arbiter

Overview:
- Sequences 68000-style bus mastership (BR/BG/BGACK) between the CPU and up to NREQ alternate masters (floppy/ACSI DMA, blitter, future masters).
- Replaces the single-flop BG emulation beside gstmcu.
- Grants only at 8 MHz bus-phase ticks, and only while the CPU address strobe is idle.
- Adds per-master grant timeout and a yield hint so one master cannot starve the others.

Parameters:
- NREQ, 2, number of alternate bus masters; index 0 = DMA, 1 = blitter.
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority starting after the last owner.
- GRANT_TIMEOUT, 8, clk_en ticks a granted master has to assert busy before the grant is withdrawn.
- MAX_HOLD, 64, clk_en ticks of ownership after which yield is raised if another master is requesting.

Ports:
- clk32 in 1: 32 MHz system clock.
- reset in 1: synchronous, active-high.
- clk_en in 1: MHZ8_EN1 bus-phase enable; all state changes except reset qualify on it.
- as_n in 1: CPU address strobe, active-low.
- req in NREQ: bus request per master, active-high, level.
- busy in NREQ: per-master BGACK equivalent, active-high, level.
- grant out NREQ: one-hot bus grant, registered.
- owner out $clog2(NREQ) (min 1): index of the current or pending owner; 0 when idle.
- bgack_n out 1: registered ~(busy[owner]) while in OWNED, otherwise 1.
- bus_free out 1: CPU may run bus cycles; registered.
- yield out NREQ: one-hot request to the owner to finish early.
- timeout out 1: one-clk32 pulse when a grant is withdrawn for lack of busy.
- err_busy out 1: sticky flag, set when a non-owner asserts busy; cleared only by reset.

Behaviour:
- Reset (synchronous, overrides clk_en): state=IDLE, grant=0, owner=0, bgack_n=1, bus_free=1, yield=0, timeout=0, err_busy=0, rr_ptr=0, counters=0.
- All transitions below occur at a posedge clk32 with clk_en=1. Outputs are registered and update on that same edge.
- IDLE:
  - If any req bit is set, the winner is chosen by the picker.
  - With as_n=1: go to GRANT, set grant[winner], set bus_free=0.
  - With as_n=0: go to WAIT_AS, latch owner=winner, bus_free stays 1.
- WAIT_AS:
  - If req[owner]=0: go to IDLE (withdrawn, no grant).
  - Else if as_n=1: go to GRANT. grant[owner]=1, bus_free=0.
  - The winner is not re-arbitrated in this state.
- GRANT:
  - If busy[owner]=1: go to OWNED, grant=0, bgack_n=0.
  - Else if req[owner]=0: go to IDLE, grant=0, bus_free=1.
  - Else increment tcnt. When tcnt reaches GRANT_TIMEOUT-1: go to IDLE, grant=0, bus_free=1, pulse timeout.
  - tcnt clears on leaving GRANT.
- OWNED:
  - If busy[owner]=0: go to RELEASE, bgack_n=1.
  - Else increment hcnt, saturating.
  - yield[owner]=1 while hcnt>=MAX_HOLD and (req & ~onehot(owner))!=0.
- RELEASE:
  - One tick of turnaround, then IDLE with bus_free=1 and yield=0.
  - If ROUND_ROBIN=1, rr_ptr=(owner+1) mod NREQ.
  - hcnt clears.
- Latency: req set at tick t with as_n=1 gives grant visible after tick t. End of busy at tick t gives bus_free after tick t+1.
- Simultaneous requests: exactly one grant bit at any time. Fixed priority picks the lowest index. Round robin picks the first set bit at or after rr_ptr, wrapping.
- busy from a non-owner in any state: ignored for state purposes; err_busy is set.
- req dropped while OWNED: ignored; busy alone governs release.
- clk_en=0: every output holds, except the timeout pulse, which is cleared on the next clk32.

Decomposition:
- Package ste_bus_pkg holds:
  - Enum arb_state_t {IDLE, WAIT_AS, GRANT, OWNED, RELEASE}.
  - Constants REQ_DMA=0, REQ_BLIT=1.
  - Function onehot(idx).
- Sub-module bus_prio_sel: combinational rotating priority encoder.
  - Inputs: req, rr_ptr, rr_en.
  - Outputs: winner index, valid.
  - Reusable by the shifter sound/video slot scheduler.

Test Plan:
- Reset with req=2'b11, as_n=0: grant=0, bus_free=1, bgack_n=1. Release reset; req=2'b01, as_n=1 at tick 0: grant=2'b01 after tick 0. busy[0]=1 at tick 2: grant=0, bgack_n=0. busy[0]=0 at tick 10: bus_free=1 after tick 11.
- as_n=0 for 3 ticks with req=2'b10: state WAIT_AS, grant=0. Raise as_n: grant=2'b10 on the next tick, owner=1.
- req=2'b11, ROUND_ROBIN=0: DMA wins twice in a row. With ROUND_ROBIN=1, grants alternate 01,10,01 across three complete ownerships.
- req=2'b01 granted, busy never asserted: timeout pulses after 8 clk_en ticks, grant returns to 0, bus_free=1. A re-requesting master is re-granted on the next tick.
- Blitter owns for 64 ticks while req[0]=1: yield=2'b10 from tick 64 until busy[1] drops. DMA is granted after RELEASE.
- busy[1]=1 while DMA owns: err_busy=1, DMA ownership unaffected. Reset asserted mid-OWNED: all outputs at reset values on the next clk32 edge, independent of clk_en.
